fifo_read_ctrl: RTL

Read-side pointer and flag controller for the async FIFO. It consumes a Gray-coded write pointer that is already synchronized into the read clock domain. It produces the binary read address for the RAM, a registered Gray read pointer for synchronization back to the write domain, and the empty, level and underflow status. It is the reader counterpart of the write-side pointer/counter logic.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_read_ctrl_gray_to_bin.sv | 14 +
 rtl/fifo_read_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write controllers.
// Gray/binary conversions work on any width up to 32 bits; callers truncate.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Upper bits of g must be zero so the prefix XOR starts clean.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR
// of all Gray bits at or above its position.
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer/flag controller for the async FIFO.
// Every output comes straight from a flop; the Gray pointer feeds a CDC sync.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic                  o_rd_ack,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ack_q, ack_d;
  logic          uflow_q, uflow_d;
  logic [PW-1:0] wr_bin;
  logic          accept;

  gray_to_bin #(
    .W (PW)
  ) u_wr_g2b (
    .i_gray (i_wr_ptr_gray),
    .o_bin  (wr_bin)
  );

  assign accept = i_rd_en & ~empty_q;

  // Flags are computed from the post-accept pointer so the last read
  // raises empty on the same edge.
  always_comb begin
    rd_ptr_d  = rd_ptr_q + PW'(accept);
    rd_gray_d = PW'(bin2gray(32'(rd_ptr_d)));
    empty_d   = (rd_gray_d == i_wr_ptr_gray);
    level_d   = wr_bin - rd_ptr_d;
    ack_d     = accept;
    uflow_d   = uflow_q | (i_rd_en & empty_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q  <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      ack_q     <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      ack_q     <= ack_d;
      uflow_q   <= uflow_d;
    end
  end

  assign o_rd_addr     = rd_ptr_q[ADDR_WIDTH-1:0];
  assign o_rd_ptr_gray = rd_gray_q;
  assign o_rd_ack      = ack_q;
  assign o_empty       = empty_q;
  assign o_level       = level_q;
  assign o_underflow   = uflow_q;

endmodule
